// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Optional feature: define UART_SCHED_TAG_EN to send a tag byte {4'hA, grant_id} ahead of each data byte.

module uart_tx_scheduler #(
    parameter int  NUM_REQ      = 4,
    parameter int  BUSY_TIMEOUT = 16,
    localparam int IDW          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    // The counter holds cycles already waited; reaching this value means BUSY_TIMEOUT-1 cycles elapsed.
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 2);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_BUSY  = 3'd2,
        ST_WAIT_DONE  = 3'd3
`ifdef UART_SCHED_TAG_EN
        ,
        ST_TAG_LAUNCH    = 3'd4,
        ST_TAG_WAIT_BUSY = 3'd5,
        ST_TAG_WAIT_DONE = 3'd6
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 active_q, active_d;
    logic                 err_q, err_d;
`ifdef UART_SCHED_TAG_EN
    logic [7:0]           hold_q, hold_d;
`endif

    logic                 win_found_s;
    logic [IDW-1:0]       win_id_s;
    logic [7:0]           win_data_s;
    logic [NUM_REQ-1:0]   above_mask_s;
    logic [NUM_REQ-1:0]   cand_s;
    logic                 timeout_s;

    function automatic logic [IDW-1:0] lowest_idx(input logic [NUM_REQ-1:0] vec);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Round-robin winner: lowest valid index above the pointer, else lowest valid index overall.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            above_mask_s[i] = (IDW'(i) > ptr_q);
        end
        cand_s      = (|(req_valid & above_mask_s)) ? (req_valid & above_mask_s) : req_valid;
        win_found_s = |req_valid;
        win_id_s    = lowest_idx(cand_s);
        win_data_s  = req_data[{win_id_s, 3'b000} +: 8];
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        req_ready_d = '0;
        timeout_s   = 1'b0;
`ifdef UART_SCHED_TAG_EN
        hold_d      = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found_s && !tx_busy) begin
                    ptr_d   = win_id_s;
                    grant_d = win_id_s;
                    tx_en_d = 1'b1;
`ifdef UART_SCHED_TAG_EN
                    hold_d    = win_data_s;
                    tx_data_d = {4'hA, 4'(win_id_s)};
                    state_d   = ST_TAG_LAUNCH;
`else
                    tx_data_d             = win_data_s;
                    req_ready_d[win_id_s] = 1'b1;
                    state_d               = ST_LAUNCH;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
`ifdef UART_SCHED_TAG_EN
            ST_TAG_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_TAG_WAIT_BUSY;
            end
            ST_TAG_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_TAG_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // Tag finished: launch the held data byte and acknowledge the requester now.
            ST_TAG_WAIT_DONE: begin
                if (!tx_busy) begin
                    tx_data_d            = hold_q;
                    tx_en_d              = 1'b1;
                    req_ready_d[grant_q] = 1'b1;
                    state_d              = ST_LAUNCH;
                end else begin
                    state_d = ST_TAG_WAIT_DONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_d    = timeout_s | (err_q & ~err_clr);
        active_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDW'(NUM_REQ - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_en_q     <= 1'b0;
            req_ready_q <= '0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
`ifdef UART_SCHED_TAG_EN
            hold_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            req_ready_q <= req_ready_d;
            active_q    <= active_d;
            err_q       <= err_d;
`ifdef UART_SCHED_TAG_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign timeout_err = err_q;

endmodule
